pingpong_buf_ctrl: RTL

//  Ping-pong controller for two external syncSRAM banks (1-cycle registered read) between a feature-map producer and a PE-array consumer.

---
 rtl/pingpong_buf_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong controller for two single-port-per-direction sync SRAM banks.
// The producer fills one bank while the consumer drains the other. The two
// roles swap when a tile completes. This block owns all bank addressing and
// per-bank status. The datapath is only the write-data pass-through and the
// read-data mux.
module pingpong_buf_ctrl #(
    parameter int unsigned DW       = 256,
    parameter int unsigned AW       = 8,
    parameter int unsigned TILE_LEN = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic          rd_avail,
    output logic          rd_dvalid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          rd_err,
    output logic [15:0]   tiles_done,
    output logic [1:0]    sram_we,
    output logic [AW-1:0] sram_wa,
    output logic [DW-1:0] sram_wd,
    output logic [1:0]    sram_re,
    output logic [AW-1:0] sram_ra,
    input  logic [DW-1:0] sram_rd0,
    input  logic [DW-1:0] sram_rd1
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_FULL,
        ST_DRAINING
    } bank_st_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(TILE_LEN - 1);

    bank_st_t        status_q [2];
    bank_st_t        status_d [2];
    logic            wbank_q, wbank_d;
    logic            rbank_q, rbank_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [15:0]     tiles_q, tiles_d;
    logic            rsel_q;
    logic            rd_dvalid_q;
    logic            rd_last_q;
    logic            rd_err_q;

    logic            wr_fire;
    logic            rd_fire;
    logic            wr_last;
    logic            rd_last_fire;

    // Handshakes come from registered status only. They are gated while reset is held.
    always_comb begin
        wr_ready     = ~rst & ((status_q[wbank_q] == ST_EMPTY) ||
                               (status_q[wbank_q] == ST_FILLING));
        rd_avail     = ~rst & ((status_q[rbank_q] == ST_FULL) ||
                               (status_q[rbank_q] == ST_DRAINING));
        wr_fire      = wr_valid & wr_ready;
        rd_fire      = rd_en & rd_avail;
        wr_last      = (wptr_q == LAST_IDX);
        rd_last_fire = rd_fire & (rptr_q == LAST_IDX);
    end

    // SRAM port drive: per-bank strobes, shared addresses, write data pass-through
    always_comb begin
        sram_we = {wr_fire & wbank_q, wr_fire & ~wbank_q};
        sram_re = {rd_fire & rbank_q, rd_fire & ~rbank_q};
        sram_wa = wptr_q;
        sram_ra = rptr_q;
        sram_wd = wr_data;
    end

    // Next-state for bank status, pointers and the drained-tile count.
    // A write and a read never target the same bank. A bank being written is
    // EMPTY/FILLING and a bank being read is FULL/DRAINING. So both updates apply.
    always_comb begin
        status_d[0] = status_q[0];
        status_d[1] = status_q[1];
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        tiles_d     = tiles_q;

        if (wr_fire) begin
            if (wr_last) begin
                status_d[wbank_q] = ST_FULL;
                wptr_d            = '0;
                wbank_d           = ~wbank_q;
            end else begin
                status_d[wbank_q] = ST_FILLING;
                wptr_d            = wptr_q + AW'(1);
            end
        end

        if (rd_fire) begin
            if (rd_last_fire) begin
                status_d[rbank_q] = ST_EMPTY;
                rptr_d            = '0;
                rbank_d           = ~rbank_q;
                tiles_d           = tiles_q + 16'd1;
            end else begin
                status_d[rbank_q] = ST_DRAINING;
                rptr_d            = rptr_q + AW'(1);
            end
        end
    end

    // State registers. Flush clears the same state as rst, but synchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q[0] <= ST_EMPTY;
            status_q[1] <= ST_EMPTY;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            tiles_q     <= '0;
            rsel_q      <= 1'b0;
            rd_dvalid_q <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_err_q    <= 1'b0;
        end else if (flush) begin
            status_q[0] <= ST_EMPTY;
            status_q[1] <= ST_EMPTY;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            tiles_q     <= '0;
            rsel_q      <= 1'b0;
            rd_dvalid_q <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            status_q[0] <= status_d[0];
            status_q[1] <= status_d[1];
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            tiles_q     <= tiles_d;
            if (rd_fire) begin
                rsel_q <= rbank_q;
            end
            rd_dvalid_q <= rd_fire;
            rd_last_q   <= rd_last_fire;
            rd_err_q    <= rd_en & ~rd_avail;
        end
    end

    // Read return path: the bank selected at fire time picks the SRAM output
    always_comb begin
        rd_data    = rsel_q ? sram_rd1 : sram_rd0;
        rd_dvalid  = rd_dvalid_q;
        rd_last    = rd_last_q;
        rd_err     = rd_err_q;
        tiles_done = tiles_q;
    end

endmodule
